// File: rtl/cpc_write_fifo_sequencer.sv
// Queues decoded CPC I/O writes and hands them to the ATMega through a four-phase
// VALID/ACK handshake. Both asynchronous inputs are synchronised; serial mode flushes the queue.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  S_IDLE     | nothing presented; waiting for a queued byte and ACK low
//  S_PRESENT  | head byte driven with VALID high; waiting for ACK high
//  S_WAIT_LOW | head popped, VALID low; waiting for ATMega to release ACK
module cpc_write_fifo_sequencer #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       iCLK,
    input  logic                       i_RESET,
    input  logic                       iWR_STROBE,
    input  logic [7:0]                 iCPC_DATA,
    input  logic                       iSERIAL_MODE,
    output logic [7:0]                 oATMEGA_DATA,
    output logic                       oATMEGA_VALID,
    input  logic                       iATMEGA_ACK,
    output logic [$clog2(DEPTH):0]     oFIFO_COUNT,
    output logic                       oFIFO_FULL,
    output logic                       oOVERFLOW,
    input  logic                       iOVF_CLEAR
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = 2;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PRESENT  = 2'd1;
    localparam logic [1:0] S_WAIT_LOW = 2'd2;

    logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   wr_prev_q, wr_prev_d;
    logic                   armed_q, armed_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [7:0]             mem_q [DEPTH];
    logic [7:0]             mem_d [DEPTH];
    logic [AW-1:0]          rp_q, rp_d;
    logic [AW-1:0]          wp_q, wp_d;
    logic [CW-1:0]          count_q, count_d;
    logic [1:0]             state_q, state_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;

    logic wr_s, ack_s, full, push_req, pop, push, ovf_set;

    assign wr_s  = wr_sync_q[SYNC_STAGES-1];
    assign ack_s = ack_sync_q[SYNC_STAGES-1];
    assign full  = (count_q == CW'(DEPTH));

    // The chain holds reset zeros for SYNC_STAGES cycles; edges are only trusted once
    // a genuine low sample has been seen, so a strobe held through reset does not push.
    assign push_req = armed_q & wr_s & ~wr_prev_q;
    assign pop      = (state_q == S_PRESENT) & ack_s;
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop & ~iSERIAL_MODE;

    always_comb begin
        wr_sync_d  = {wr_sync_q[SYNC_STAGES-2:0], iWR_STROBE};
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], iATMEGA_ACK};
        wr_prev_d  = wr_s;
        fill_d     = (fill_q != '0) ? fill_q - 1'b1 : fill_q;
        armed_d    = armed_q | ((fill_q == '0) & ~wr_s);

        mem_d   = mem_q;
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;

        if (push) begin
            mem_d[wp_q] = iCPC_DATA;
            wp_d        = wp_q + 1'b1;
        end
        if (pop) begin
            rp_d = rp_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !ack_s) begin
                    data_d  = mem_q[rp_q];
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (ack_s) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!ack_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Set beats clear; serial mode keeps the flag.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (iOVF_CLEAR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (iSERIAL_MODE) begin
            mem_d   = mem_q;
            rp_d    = '0;
            wp_d    = '0;
            count_d = '0;
            state_d = S_IDLE;
            data_d  = 8'h00;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!i_RESET) begin
            wr_sync_q  <= '0;
            ack_sync_q <= '0;
            wr_prev_q  <= 1'b0;
            armed_q    <= 1'b0;
            fill_q     <= FW'(SYNC_STAGES);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            rp_q       <= '0;
            wp_q       <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_sync_q  <= wr_sync_d;
            ack_sync_q <= ack_sync_d;
            wr_prev_q  <= wr_prev_d;
            armed_q    <= armed_d;
            fill_q     <= fill_d;
            mem_q      <= mem_d;
            rp_q       <= rp_d;
            wp_q       <= wp_d;
            count_q    <= count_d;
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign oATMEGA_DATA  = data_q;
    assign oATMEGA_VALID = valid_q;
    assign oFIFO_COUNT   = count_q;
    assign oFIFO_FULL    = full;
    assign oOVERFLOW     = ovf_q;

endmodule

// File: tb/tb_cpc_write_fifo_sequencer.sv
// Directed bench for cpc_write_fifo_sequencer: stimulus queues expected bytes,
// a monitor compares each byte at the rising edge of VALID.
module tb_cpc_write_fifo_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_strobe;
    logic [7:0] cpc_data;
    logic       serial_mode;
    logic [7:0] at_data;
    logic       at_valid;
    logic       at_ack;
    logic [2:0] fifo_count;
    logic       fifo_full;
    logic       overflow;
    logic       ovf_clear;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    cpc_write_fifo_sequencer #(.DEPTH(4), .SYNC_STAGES(2)) dut (
        .iCLK          (clk),
        .i_RESET       (rst_n),
        .iWR_STROBE    (wr_strobe),
        .iCPC_DATA     (cpc_data),
        .iSERIAL_MODE  (serial_mode),
        .oATMEGA_DATA  (at_data),
        .oATMEGA_VALID (at_valid),
        .iATMEGA_ACK   (at_ack),
        .oFIFO_COUNT   (fifo_count),
        .oFIFO_FULL    (fifo_full),
        .oOVERFLOW     (overflow),
        .iOVF_CLEAR    (ovf_clear)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input bit expect_push);
        cpc_data  = d;
        wr_strobe = 1'b1;
        if (expect_push) exp_q.push_back(d);
        repeat (8) tick();
        wr_strobe = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wait_valid(input logic level, input string name);
        int n;
        n = 0;
        while (at_valid !== level && n < 60) begin
            tick();
            n++;
        end
        if (at_valid !== level) begin
            checks++;
            failures++;
            $display("FAIL %s timeout valid=%0b expected=%0b", name, at_valid, level);
        end
    endtask

    task automatic handshake();
        wait_valid(1'b1, "hs_valid_high");
        at_ack = 1'b1;
        wait_valid(1'b0, "hs_valid_low");
        at_ack = 1'b0;
        repeat (3) tick();
    endtask

    // Monitor: every new presentation must match the oldest expected byte.
    initial begin
        logic prev_valid;
        logic [7:0] e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (at_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL deliver unexpected byte got=%0h expected=none", at_data);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver", at_data, e);
                end
            end
            prev_valid = at_valid;
        end
    end

    initial begin
        rst_n       = 1'b0;
        wr_strobe   = 1'b1;
        cpc_data    = 8'hEE;
        serial_mode = 1'b0;
        at_ack      = 1'b0;
        ovf_clear   = 1'b0;

        // Reset with strobe held high
        repeat (3) tick();
        check("rst_valid", at_valid, 1'b0);
        check("rst_data", at_data, 8'h00);
        check("rst_count", fifo_count, 3'd0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        repeat (6) tick();
        check("rst_no_push", fifo_count, 3'd0);
        wr_strobe = 1'b0;
        repeat (5) tick();
        check("rst_still_empty", fifo_count, 3'd0);

        // Single byte with exact latency
        cpc_data  = 8'h5A;
        wr_strobe = 1'b1;
        exp_q.push_back(8'h5A);
        tick(); tick();
        check("single_count_c2", fifo_count, 3'd0);
        tick();
        check("single_count_c3", fifo_count, 3'd1);
        check("single_valid_c3", at_valid, 1'b0);
        tick();
        check("single_valid_c4", at_valid, 1'b1);
        check("single_data_c4", at_data, 8'h5A);
        repeat (4) tick();
        wr_strobe = 1'b0;
        repeat (3) tick();
        check("single_count_held", fifo_count, 3'd1);
        at_ack = 1'b1;
        tick(); tick();
        check("single_valid_ack2", at_valid, 1'b1);
        tick();
        check("single_valid_ack3", at_valid, 1'b0);
        check("single_count_pop", fifo_count, 3'd0);
        check("single_data_held", at_data, 8'h5A);
        at_ack = 1'b0;
        repeat (4) tick();
        check("single_idle_valid", at_valid, 1'b0);

        // Burst overflow
        for (int i = 1; i <= 5; i++) write_byte(8'(i), i <= 4);
        check("burst_count", fifo_count, 3'd4);
        check("burst_full", fifo_full, 1'b1);
        check("burst_ovf", overflow, 1'b1);
        repeat (4) handshake();
        check("burst_drained", fifo_count, 3'd0);
        check("burst_ovf_kept", overflow, 1'b1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Simultaneous push and pop on a full FIFO
        for (int i = 0; i < 4; i++) write_byte(8'h31 + 8'(i), 1'b1);
        check("simul_full", fifo_full, 1'b1);
        check("simul_valid", at_valid, 1'b1);
        cpc_data  = 8'h35;
        wr_strobe = 1'b1;
        at_ack    = 1'b1;
        exp_q.push_back(8'h35);
        repeat (3) tick();
        check("simul_count", fifo_count, 3'd4);
        check("simul_valid_low", at_valid, 1'b0);
        check("simul_no_ovf", overflow, 1'b0);
        repeat (5) tick();
        wr_strobe = 1'b0;
        at_ack    = 1'b0;
        repeat (4) tick();
        check("simul_count_after", fifo_count, 3'd4);
        check("simul_no_ovf_after", overflow, 1'b0);
        repeat (4) handshake();
        check("simul_drained", fifo_count, 3'd0);

        // Pointer wrap
        for (int i = 0; i < 10; i++) begin
            write_byte(8'h10 + 8'(i), 1'b1);
            handshake();
        end
        check("wrap_count", fifo_count, 3'd0);
        check("wrap_ovf", overflow, 1'b0);

        // Serial mode mid-handshake
        write_byte(8'h41, 1'b1);
        write_byte(8'h42, 1'b1);
        write_byte(8'h43, 1'b1);
        check("serial_pre_count", fifo_count, 3'd3);
        check("serial_pre_valid", at_valid, 1'b1);
        serial_mode = 1'b1;
        tick();
        exp_q.delete();
        check("serial_valid", at_valid, 1'b0);
        check("serial_count", fifo_count, 3'd0);
        check("serial_data", at_data, 8'h00);
        write_byte(8'h99, 1'b0);
        check("serial_ignored", fifo_count, 3'd0);
        check("serial_no_ovf", overflow, 1'b0);
        serial_mode = 1'b0;
        tick();
        write_byte(8'hA5, 1'b1);
        handshake();
        check("serial_resume_count", fifo_count, 3'd0);

        repeat (5) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
